// File: rtl/tmu2_deserialize.sv
// tmu2_deserialize: gathers serial (adr, idx, last) beats into one four-wide
// texel address bundle for the downstream TMU2 stage. While a bundle waits
// for acceptance, no input is taken, so a finished group is never overwritten.
module tmu2_deserialize #(
    parameter int fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    output logic                 busy,
    input  logic                 pipe_stb_i,
    output logic                 pipe_ack_o,
    input  logic [fml_depth-6:0] adr,
    input  logic [1:0]           idx,
    input  logic                 last,
    output logic                 pipe_stb_o,
    input  logic                 pipe_ack_i,
    output logic [fml_depth-6:0] tadra,
    output logic [fml_depth-6:0] tadrb,
    output logic [fml_depth-6:0] tadrc,
    output logic [fml_depth-6:0] tadrd,
    output logic                 miss_a,
    output logic                 miss_b,
    output logic                 miss_c,
    output logic                 miss_d,
    output logic [15:0]          groups
);

    localparam int AW = fml_depth - 5;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] OUTPUT  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [3:0][AW-1:0]  slot_q, slot_d;
    logic [3:0]          mask_q, mask_d;
    logic [15:0]         groups_q, groups_d;

    // Next-state: fill slots while collecting, clear everything once the bundle is taken.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        mask_d   = mask_q;
        groups_d = groups_q;
        case (state_q)
            COLLECT: begin
                if (pipe_stb_i) begin
                    slot_d[idx] = adr;
                    mask_d[idx] = 1'b1;
                    if (last) begin
                        state_d = OUTPUT;
                    end
                end
            end
            default: begin
                if (pipe_ack_i) begin
                    slot_d   = '0;
                    mask_d   = '0;
                    groups_d = groups_q + 16'd1;
                    state_d  = COLLECT;
                end
            end
        endcase
    end

    // State registers; reset drops any partial or pending bundle.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q  <= COLLECT;
            slot_q   <= '0;
            mask_q   <= '0;
            groups_q <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            mask_q   <= mask_d;
            groups_q <= groups_d;
        end
    end

    // Handshakes and status depend only on registered state, never on inputs.
    always_comb begin
        pipe_ack_o = (state_q == COLLECT);
        pipe_stb_o = (state_q == OUTPUT);
        busy       = (state_q == OUTPUT) || (mask_q != 4'd0);
    end

    assign tadra  = slot_q[0];
    assign tadrb  = slot_q[1];
    assign tadrc  = slot_q[2];
    assign tadrd  = slot_q[3];
    assign miss_a = mask_q[0];
    assign miss_b = mask_q[1];
    assign miss_c = mask_q[2];
    assign miss_d = mask_q[3];
    assign groups = groups_q;

endmodule
